// File: rtl/hrm_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : hrm_pkg
//  Brief    : Shared constants and encodings for the hrmcpu snapshot
//             controller: dump-mux chip selects, frame header default,
//             controller FSM states and frame item indices.
//  Revision : 1.0 - initial release
// ============================================================================
package hrm_pkg;

    // Dump-mux chip-select codes understood by the hrmcpu top
    localparam logic [2:0] M_INBOX  = 3'd0;
    localparam logic [2:0] M_OUTBOX = 3'd1;
    localparam logic [2:0] M_PC     = 3'd2;
    localparam logic [2:0] M_RAM    = 3'd3;
    localparam logic [2:0] M_REG    = 3'd4;
    localparam logic [2:0] M_INSTR  = 3'd5;

    // Default first byte of every snapshot frame
    localparam logic [7:0] HDR_DEFAULT = 8'hA5;

    // Controller sequencing states
    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_HOLD   = 3'd1,
        ST_SETTLE = 3'd2,
        ST_SAMPLE = 3'd3,
        ST_COUNT  = 3'd4,
        ST_EMIT   = 3'd5,
        ST_DONE   = 3'd6
    } state_t;

    // Position within the snapshot frame
    typedef enum logic [3:0] {
        ITEM_HDR   = 4'd0,
        ITEM_PC    = 4'd1,
        ITEM_INSTR = 4'd2,
        ITEM_REG   = 4'd3,
        ITEM_NIN   = 4'd4,
        ITEM_IN    = 4'd5,
        ITEM_NOUT  = 4'd6,
        ITEM_OUT   = 4'd7,
        ITEM_CK    = 4'd8
    } item_t;

endpackage
`default_nettype wire

// File: rtl/hrm_snapshot_ctrl_if.sv
`default_nettype none
// ============================================================================
//  Module   : hrm_snapshot_ctrl_if
//  Brief    : Bundles the dump-mux access bus (towards the hrmcpu) and the
//             byte stream (towards the UART TX). Signal prefixes are as seen
//             from the snapshot controller, which uses the master modport.
//  Revision : 1.0 - initial release
// ============================================================================
interface hrm_snapshot_ctrl_if #(
    parameter int LGFLEN = 5
);
    logic [2:0]        o_dmp_chip_select;
    logic [LGFLEN-1:0] o_dmp_fifo_pos;
    logic [7:0]        i_dmp_data;
    logic              i_dmp_valid;
    logic [7:0]        o_tx_data;
    logic              o_tx_valid;
    logic              i_tx_ready;

    modport master (
        output o_dmp_chip_select, o_dmp_fifo_pos, o_tx_data, o_tx_valid,
        input  i_dmp_data, i_dmp_valid, i_tx_ready
    );

    modport slave (
        input  o_dmp_chip_select, o_dmp_fifo_pos, o_tx_data, o_tx_valid,
        output i_dmp_data, i_dmp_valid, i_tx_ready
    );
endinterface
`default_nettype wire

// File: rtl/hrm_tx_slot.sv
`default_nettype none
// ============================================================================
//  Module   : hrm_tx_slot
//  Brief    : One-entry output register with valid/ready hold semantics.
//             A push is taken only while empty; data is held unchanged until
//             the sink accepts it.
//  Revision : 1.0 - initial release
// ============================================================================
module hrm_tx_slot #(
    parameter int WIDTH = 8
) (
    input  wire logic             clk,
    input  wire logic             i_rst_n,
    input  wire logic             i_push,
    input  wire logic [WIDTH-1:0] i_data,
    output logic                  o_full,
    output logic [WIDTH-1:0]      o_data,
    output logic                  o_valid,
    input  wire logic             i_ready
);
    logic             r_valid;
    logic [WIDTH-1:0] r_data;

    // Load when empty, drop valid once the sink has taken the byte
    always_ff @(posedge clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_valid <= 1'b0;
            r_data  <= '0;
        end else if (i_push && !r_valid) begin
            r_valid <= 1'b1;
            r_data  <= i_data;
        end else if (r_valid && i_ready) begin
            r_valid <= 1'b0;
        end
    end

    assign o_full  = r_valid;
    assign o_valid = r_valid;
    assign o_data  = r_data;
endmodule
`default_nettype wire

// File: rtl/hrm_snapshot_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : hrm_snapshot_ctrl
//  Brief    : Freezes the hrmcpu, walks its dump mux and serialises the CPU
//             state as HDR, PC, INSTR, REG, NIN, INBOX.., NOUT, OUTBOX.. on a
//             valid/ready byte stream.
//             Optional macro HRM_SNAP_CKSUM_EN appends a zero-sum checksum.
//  Revision : 1.0 - initial release
// ============================================================================
module hrm_snapshot_ctrl
    import hrm_pkg::*;
#(
    parameter int         LGFLEN      = 5,
    parameter int         HOLD_CYCLES = 4,
    parameter logic [7:0] HDR         = HDR_DEFAULT
) (
    input  wire logic           clk,
    input  wire logic           i_rst_n,
    input  wire logic           i_snap_req,
    output logic                o_busy,
    output logic                o_hold,
    hrm_snapshot_ctrl_if.master bus
);
    localparam int c_CW   = LGFLEN + 1;
    localparam int c_HC_W = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;
    localparam logic [c_HC_W-1:0] c_HOLD_LOAD = c_HC_W'(HOLD_CYCLES - 1);
    localparam logic [LGFLEN-1:0] c_POS_MAX   = '1;
`ifdef HRM_SNAP_CKSUM_EN
    localparam logic c_CK_EN = 1'b1;
`else
    localparam logic c_CK_EN = 1'b0;
`endif

    state_t            r_state;
    item_t             r_item;
    logic              r_busy;
    logic              r_hold;
    logic [2:0]        r_sel;
    logic [LGFLEN-1:0] r_pos;
    logic [c_HC_W-1:0] r_holdcnt;
    logic [c_CW-1:0]   r_cnt;
    logic              r_counting;
    logic              r_smp_valid;
    logic [7:0]        r_byte;
    logic              r_pushed;

    logic              w_full;
    logic              w_push;
    logic              w_xfer;
    logic [7:0]        w_tx_data;
    logic              w_tx_valid;
    logic [7:0]        w_ck_byte;
    logic [c_CW-1:0]   w_cnt_inc;
    logic [c_CW-1:0]   w_pos_inc;
    logic              w_last;

    item_t             w_nxt_item;
    logic [2:0]        w_nxt_sel;
    logic [LGFLEN-1:0] w_nxt_pos;
    logic              w_nxt_counting;
    logic              w_nxt_ck;
    logic              w_nxt_finish;

    assign w_cnt_inc = r_cnt + c_CW'(1);
    assign w_pos_inc = {1'b0, r_pos} + c_CW'(1);
    assign w_last    = (w_pos_inc == r_cnt);
    assign w_push    = (r_state == ST_EMIT) && !r_pushed && !w_full;
    assign w_xfer    = w_tx_valid && bus.i_tx_ready;

    // Decide what follows the item whose byte is currently being transferred
    always_comb begin
        w_nxt_item     = r_item;
        w_nxt_sel      = r_sel;
        w_nxt_pos      = '0;
        w_nxt_counting = 1'b0;
        w_nxt_ck       = 1'b0;
        w_nxt_finish   = 1'b0;
        case (r_item)
            ITEM_HDR: begin
                w_nxt_item = ITEM_PC;
                w_nxt_sel  = M_PC;
            end
            ITEM_PC: begin
                w_nxt_item = ITEM_INSTR;
                w_nxt_sel  = M_INSTR;
            end
            ITEM_INSTR: begin
                w_nxt_item = ITEM_REG;
                w_nxt_sel  = M_REG;
            end
            ITEM_REG: begin
                w_nxt_item     = ITEM_NIN;
                w_nxt_sel      = M_INBOX;
                w_nxt_counting = 1'b1;
            end
            ITEM_NIN, ITEM_IN: begin
                if ((r_item == ITEM_NIN && r_cnt == '0) || (r_item == ITEM_IN && w_last)) begin
                    w_nxt_item     = ITEM_NOUT;
                    w_nxt_sel      = M_OUTBOX;
                    w_nxt_counting = 1'b1;
                end else begin
                    w_nxt_item = ITEM_IN;
                    w_nxt_sel  = M_INBOX;
                    w_nxt_pos  = (r_item == ITEM_NIN) ? '0 : r_pos + LGFLEN'(1);
                end
            end
            ITEM_NOUT, ITEM_OUT: begin
                if ((r_item == ITEM_NOUT && r_cnt == '0) || (r_item == ITEM_OUT && w_last)) begin
                    w_nxt_ck     = c_CK_EN;
                    w_nxt_finish = !c_CK_EN;
                end else begin
                    w_nxt_item = ITEM_OUT;
                    w_nxt_sel  = M_OUTBOX;
                    w_nxt_pos  = (r_item == ITEM_NOUT) ? '0 : r_pos + LGFLEN'(1);
                end
            end
            default: begin
                w_nxt_finish = 1'b1;
            end
        endcase
    end

`ifdef HRM_SNAP_CKSUM_EN
    logic [7:0] r_ck;

    // Running sum of every byte after the header; cleared between frames
    always_ff @(posedge clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_ck <= 8'd0;
        end else if (r_state == ST_IDLE) begin
            r_ck <= 8'd0;
        end else if (w_push && r_item != ITEM_HDR) begin
            r_ck <= r_ck + r_byte;
        end
    end

    assign w_ck_byte = 8'd0 - r_ck;
`else
    assign w_ck_byte = 8'd0;
`endif

    // Main sequencer: hold the CPU, walk the dump mux, feed the output slot
    always_ff @(posedge clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state     <= ST_IDLE;
            r_item      <= ITEM_HDR;
            r_busy      <= 1'b0;
            r_hold      <= 1'b0;
            r_sel       <= M_PC;
            r_pos       <= '0;
            r_holdcnt   <= '0;
            r_cnt       <= '0;
            r_counting  <= 1'b0;
            r_smp_valid <= 1'b0;
            r_byte      <= 8'd0;
            r_pushed    <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (i_snap_req) begin
                        r_busy    <= 1'b1;
                        r_hold    <= 1'b1;
                        r_holdcnt <= c_HOLD_LOAD;
                        r_item    <= ITEM_HDR;
                        r_state   <= ST_HOLD;
                    end
                end
                ST_HOLD: begin
                    // The header needs no dump access, so it is staged directly
                    if (r_holdcnt == '0) begin
                        r_byte   <= HDR;
                        r_pushed <= 1'b0;
                        r_state  <= ST_EMIT;
                    end else begin
                        r_holdcnt <= r_holdcnt - c_HC_W'(1);
                    end
                end
                ST_SETTLE: begin
                    r_state <= ST_SAMPLE;
                end
                ST_SAMPLE: begin
                    r_byte      <= bus.i_dmp_data;
                    r_smp_valid <= bus.i_dmp_valid;
                    r_state     <= r_counting ? ST_COUNT : ST_EMIT;
                end
                ST_COUNT: begin
                    // Probe the next slot unless this one was empty or the last
                    if (r_smp_valid && (r_pos != c_POS_MAX)) begin
                        r_cnt   <= w_cnt_inc;
                        r_pos   <= r_pos + LGFLEN'(1);
                        r_state <= ST_SETTLE;
                    end else begin
                        r_cnt      <= r_smp_valid ? w_cnt_inc : r_cnt;
                        r_byte     <= r_smp_valid ? 8'(w_cnt_inc) : 8'(r_cnt);
                        r_counting <= 1'b0;
                        r_pushed   <= 1'b0;
                        r_state    <= ST_EMIT;
                    end
                end
                ST_EMIT: begin
                    if (!r_pushed) begin
                        if (!w_full) begin
                            r_pushed <= 1'b1;
                        end
                    end else if (w_xfer) begin
                        r_pushed <= 1'b0;
                        if (w_nxt_finish) begin
                            r_busy  <= 1'b0;
                            r_hold  <= 1'b0;
                            r_sel   <= M_PC;
                            r_pos   <= '0;
                            r_state <= ST_DONE;
                        end else if (w_nxt_ck) begin
                            r_item <= ITEM_CK;
                            r_byte <= w_ck_byte;
                        end else begin
                            r_item     <= w_nxt_item;
                            r_sel      <= w_nxt_sel;
                            r_pos      <= w_nxt_pos;
                            r_counting <= w_nxt_counting;
                            if (w_nxt_counting) begin
                                r_cnt <= '0;
                            end
                            r_state <= ST_SETTLE;
                        end
                    end
                end
                ST_DONE: begin
                    r_state <= ST_IDLE;
                end
                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

    hrm_tx_slot #(
        .WIDTH (8)
    ) u_slot (
        .clk     (clk),
        .i_rst_n (i_rst_n),
        .i_push  (w_push),
        .i_data  (r_byte),
        .o_full  (w_full),
        .o_data  (w_tx_data),
        .o_valid (w_tx_valid),
        .i_ready (bus.i_tx_ready)
    );

    assign o_busy                = r_busy;
    assign o_hold                = r_hold;
    assign bus.o_dmp_chip_select = r_sel;
    assign bus.o_dmp_fifo_pos    = r_pos;
    assign bus.o_tx_data         = w_tx_data;
    assign bus.o_tx_valid        = w_tx_valid;
endmodule
`default_nettype wire

// File: tb/tb_hrm_snapshot_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : tb_hrm_snapshot_ctrl
//  Brief    : Self-checking bench for hrm_snapshot_ctrl. A behavioural CPU
//             dump model answers the mux; captured frames are compared with
//             hand-computed frames from a vector table, plus directed
//             latency and mid-frame reset sequences.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_hrm_snapshot_ctrl;
    import hrm_pkg::*;

    localparam int LGFLEN = 5;
    localparam int DEPTH  = 32;

    logic clk = 1'b0;
    logic i_rst_n;
    logic i_snap_req;
    logic o_busy;
    logic o_hold;

    hrm_snapshot_ctrl_if #(.LGFLEN(LGFLEN)) bus ();

    hrm_snapshot_ctrl #(
        .LGFLEN      (LGFLEN),
        .HOLD_CYCLES (4),
        .HDR         (8'hA5)
    ) dut (
        .clk        (clk),
        .i_rst_n    (i_rst_n),
        .i_snap_req (i_snap_req),
        .o_busy     (o_busy),
        .o_hold     (o_hold),
        .bus        (bus.master)
    );

    always #5 clk = ~clk;

    // CPU dump model
    logic [7:0] m_pc, m_instr, m_reg;
    logic [7:0] m_in  [DEPTH];
    logic [7:0] m_out [DEPTH];
    int         m_nin, m_nout;

    always_comb begin
        bus.i_dmp_data  = 8'h00;
        bus.i_dmp_valid = 1'b0;
        case (bus.o_dmp_chip_select)
            3'd0: if (int'(bus.o_dmp_fifo_pos) < m_nin) begin
                bus.i_dmp_data  = m_in[bus.o_dmp_fifo_pos];
                bus.i_dmp_valid = 1'b1;
            end
            3'd1: if (int'(bus.o_dmp_fifo_pos) < m_nout) begin
                bus.i_dmp_data  = m_out[bus.o_dmp_fifo_pos];
                bus.i_dmp_valid = 1'b1;
            end
            3'd2: begin bus.i_dmp_data = m_pc;    bus.i_dmp_valid = 1'b1; end
            3'd4: begin bus.i_dmp_data = m_reg;   bus.i_dmp_valid = 1'b1; end
            3'd5: begin bus.i_dmp_data = m_instr; bus.i_dmp_valid = 1'b1; end
            default: ;
        endcase
    end

    // TX sink: always ready, or ready one cycle in three
    int   ready_mode = 0;
    int   rcyc       = 0;
    logic ready_q    = 1'b1;
    always @(posedge clk) begin
        #1;
        rcyc    = rcyc + 1;
        ready_q = (ready_mode == 0) ? 1'b1 : ((rcyc % 3) == 0);
    end
    assign bus.i_tx_ready = ready_q;

    // Stream monitor, sampling on the falling edge
    logic [7:0] cap[$];
    int   mon_cyc = 0, last_xfer_cyc = -10;
    int   stall_chk = 0, stall_err = 0, hold_err = 0;
    logic prev_stall = 1'b0;
    logic [7:0] prev_data = 8'h00;
    always @(negedge clk) begin
        if (bus.o_tx_valid && bus.i_tx_ready) begin
            cap.push_back(bus.o_tx_data);
            last_xfer_cyc <= mon_cyc;
        end
        if (prev_stall) begin
            stall_chk <= stall_chk + 1;
            if (!bus.o_tx_valid || bus.o_tx_data != prev_data)
                stall_err <= stall_err + 1;
        end
        if (o_busy && !o_hold) hold_err <= hold_err + 1;
        prev_stall <= bus.o_tx_valid && !bus.i_tx_ready;
        prev_data  <= bus.o_tx_data;
        mon_cyc    <= mon_cyc + 1;
    end

    int n_cmp = 0;
    int n_bad = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        n_cmp++;
        if (act !== req) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, req);
        end
    endtask

    typedef struct {
        logic [7:0] pc, instr, rg;
        int         nin;
        logic [7:0] in_base, in_step;
        int         nout;
        logic [7:0] out_base, out_step;
        int         ready_mode;
        bit         mid_req;
        int         exp_len;   // frame length without checksum
        logic [7:0] exp_ck;
    } vec_t;

    vec_t vt[5];

`ifdef HRM_SNAP_CKSUM_EN
    localparam int CKN = 1;
`else
    localparam int CKN = 0;
`endif

    task automatic load_model(input int v);
        m_pc    = vt[v].pc;
        m_instr = vt[v].instr;
        m_reg   = vt[v].rg;
        m_nin   = vt[v].nin;
        m_nout  = vt[v].nout;
        for (int i = 0; i < DEPTH; i++) begin
            m_in[i]  = 8'(vt[v].in_base + vt[v].in_step * i);
            m_out[i] = 8'(vt[v].out_base + vt[v].out_step * i);
        end
    endtask

    task automatic pulse_req();
        @(posedge clk); #1;
        i_snap_req = 1'b1;
        @(posedge clk); #1;
        i_snap_req = 1'b0;
    endtask

    task automatic run_vec(input int v);
        logic [7:0] expq[$];
        int base, got, bud, se0, hc0, sc0, n, sum;
        load_model(v);
        ready_mode = vt[v].ready_mode;
        expq.push_back(8'hA5);
        expq.push_back(vt[v].pc);
        expq.push_back(vt[v].instr);
        expq.push_back(vt[v].rg);
        expq.push_back(8'(vt[v].nin));
        for (int i = 0; i < vt[v].nin; i++) expq.push_back(m_in[i]);
        expq.push_back(8'(vt[v].nout));
        for (int i = 0; i < vt[v].nout; i++) expq.push_back(m_out[i]);
`ifdef HRM_SNAP_CKSUM_EN
        expq.push_back(vt[v].exp_ck);
`endif
        @(posedge clk); #1;
        base = cap.size();
        se0 = stall_err; hc0 = hold_err; sc0 = stall_chk;
        pulse_req();
        bud = 0;
        do begin
            @(negedge clk); #1;
            bud++;
            if (vt[v].mid_req && bud == 10) i_snap_req = 1'b1;
            if (vt[v].mid_req && bud == 11) i_snap_req = 1'b0;
        end while (o_busy && bud < 5000);
        i_snap_req = 1'b0;
        check($sformatf("v%0d timeout", v), (bud < 5000), 1'b1);
        check($sformatf("v%0d busy falls on last transfer", v), 32'(mon_cyc - 2 - last_xfer_cyc), 0);
        check($sformatf("v%0d hold low at end", v), o_hold, 1'b0);
        check($sformatf("v%0d select restored", v), bus.o_dmp_chip_select, 3'd2);
        got = cap.size() - base;
        check($sformatf("v%0d frame length", v), got, vt[v].exp_len + CKN);
        n = (got < expq.size()) ? got : expq.size();
        sum = 0;
        for (int i = 0; i < n; i++) begin
            check($sformatf("v%0d byte%0d", v, i), cap[base + i], expq[i]);
            if (i > 0) sum += cap[base + i];
        end
`ifdef HRM_SNAP_CKSUM_EN
        check($sformatf("v%0d zero-sum", v), sum % 256, 0);
`endif
        check($sformatf("v%0d data stable under stall", v), stall_err - se0, 0);
        check($sformatf("v%0d hold high while busy", v), hold_err - hc0, 0);
        if (vt[v].ready_mode != 0)
            check($sformatf("v%0d backpressure exercised", v), (stall_chk > sc0), 1'b1);
        // No second frame may follow, even after a mid-frame request
        repeat (30) @(negedge clk);
        #1;
        check($sformatf("v%0d no extra bytes", v), cap.size() - base, got);
        check($sformatf("v%0d idle after frame", v), o_busy, 1'b0);
    endtask

    initial begin
        int base, bud;
        // pc instr reg | nin base step | nout base step | ready mid | len ck
        vt[0] = '{8'h03, 8'h10, 8'h07,  2, 8'h05, 8'h04, 0, 8'h00, 8'h00, 0, 1'b0,  8, 8'hD6};
        vt[1] = '{8'h03, 8'h10, 8'h07,  2, 8'h05, 8'h04, 0, 8'h00, 8'h00, 1, 1'b0,  8, 8'hD6};
        vt[2] = '{8'h03, 8'h10, 8'h07, 32, 8'h00, 8'h01, 1, 8'h80, 8'h00, 0, 1'b0, 39, 8'h55};
        vt[3] = '{8'hFF, 8'h00, 8'h80,  0, 8'h00, 8'h00, 0, 8'h00, 8'h00, 1, 1'b1,  6, 8'h81};
        vt[4] = '{8'h40, 8'h22, 8'h01,  1, 8'h11, 8'h00, 3, 8'hF0, 8'h08, 0, 1'b1, 10, 8'hA0};

        i_rst_n    = 1'b0;
        i_snap_req = 1'b0;
        load_model(0);
        repeat (3) @(posedge clk);
        #1;
        check("reset busy",   o_busy, 1'b0);
        check("reset hold",   o_hold, 1'b0);
        check("reset select", bus.o_dmp_chip_select, 3'd2);
        check("reset pos",    bus.o_dmp_fifo_pos, 5'd0);
        check("reset txdata", bus.o_tx_data, 8'h00);
        check("reset txvld",  bus.o_tx_valid, 1'b0);
        i_rst_n = 1'b1;
        repeat (2) @(posedge clk);

        // Header latency and quiet dump bus during the hold window
        ready_mode = 0;
        @(posedge clk); #1;
        i_snap_req = 1'b1;
        @(posedge clk); #1;
        i_snap_req = 1'b0;
        for (int k = 0; k < 5; k++) begin
            @(negedge clk); #1;
            check($sformatf("lat hold k%0d", k), o_hold, 1'b1);
            check($sformatf("lat txvld k%0d", k), bus.o_tx_valid, 1'b0);
            check($sformatf("lat select k%0d", k), bus.o_dmp_chip_select, 3'd2);
            check($sformatf("lat pos k%0d", k), bus.o_dmp_fifo_pos, 5'd0);
        end
        @(negedge clk); #1;
        check("lat hdr valid", bus.o_tx_valid, 1'b1);
        check("lat hdr data",  bus.o_tx_data, 8'hA5);
        bud = 0;
        while (o_busy && bud < 2000) begin @(negedge clk); #1; bud++; end
        check("lat frame timeout", (bud < 2000), 1'b1);
        repeat (5) @(posedge clk);

        // Table-driven frames
        for (int v = 0; v < 5; v++) run_vec(v);

        // Asynchronous reset during INBOX emission, then a fresh frame
        load_model(2);
        ready_mode = 0;
        @(posedge clk); #1;
        base = cap.size();
        pulse_req();
        bud = 0;
        while ((cap.size() - base) < 8 && bud < 2000) begin @(negedge clk); #1; bud++; end
        check("rst reach inbox", (bud < 2000), 1'b1);
        @(posedge clk); #2;
        i_rst_n = 1'b0;
        #1;
        check("rst txvld",  bus.o_tx_valid, 1'b0);
        check("rst busy",   o_busy, 1'b0);
        check("rst hold",   o_hold, 1'b0);
        check("rst select", bus.o_dmp_chip_select, 3'd2);
        @(posedge clk); #1;
        i_rst_n = 1'b1;
        repeat (2) @(posedge clk);
        run_vec(2);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    // Absolute time limit as a safety net
    initial begin
        #2000000;
        $display("FAIL global timeout: got no finish, want finish");
        $fatal(1);
    end
endmodule
`default_nettype wire
